// File: rtl/sprite_pkg.sv
// sprite_pkg
//   Shared definitions for the sprite fetcher: bus widths, the transparent
//   colour key, the fetch FSM state type, the packed pixel record carried
//   through the output FIFO, and the sprite dimension clamp.
package sprite_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;
    localparam logic [DATA_W-1:0] TRANSPARENT = 8'h00;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN
    } fetch_state_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [3:0]        x;
        logic [3:0]        y;
        logic              opaque;
    } pix_t;

    // Sprite dimensions are at most 16; larger requests are treated as 16.
    function automatic logic [4:0] clamp_dim(input logic [4:0] v);
        return (v > 5'd16) ? 5'd16 : v;
    endfunction

endpackage

// File: rtl/sprite_fetch_pix_fifo2.sv
// pix_fifo2
//   Two-entry FIFO of pix_t records between the colour memory return path
//   and the pixel output stream. The head entry is presented combinationally.
//   Ports:
//     clk, rst_n      clock, asynchronous active-low reset (clears entries)
//     push, din       write request and record
//     pop             remove the head entry
//     dout            head entry
//     full, empty     occupancy flags
//     count           number of stored entries (0..2)
module pix_fifo2
    import sprite_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  pix_t       din,
    input  logic       pop,
    output pix_t       dout,
    output logic       full,
    output logic       empty,
    output logic [1:0] count
);

    pix_t       mem_q [2];
    pix_t       mem_d [2];
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] count_q, count_d;
    logic       do_push, do_pop;

    assign full  = (count_q == 2'd2);
    assign empty = (count_q == 2'd0);
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        do_pop   = pop && !empty;
        // A push into a full FIFO is accepted only when the head leaves at the same edge.
        do_push  = push && (!full || do_pop);
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/sprite_fetch.sv
// sprite_fetch
//   Walks a Width x Height sprite stored row-major at Base, issuing one
//   colour memory read per cycle when there is room downstream, and streams
//   each returned byte with its X/Y position and opaque flag.
//   Ports:
//     Clk, Reset               clock, asynchronous active-low reset
//     Start, Base, Width, Height  sprite request (sampled only in IDLE)
//     Busy, Done               activity level and completion pulse
//     Mem_A, Mem_Q             colour memory read address / registered data
//     Pix_Valid, Pix_Ready     output stream handshake
//     Pix_Data, Pix_X, Pix_Y, Pix_Opaque  output pixel record
module sprite_fetch
    import sprite_pkg::*;
(
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic [ADDR_W-1:0] Base,
    input  logic [4:0]        Width,
    input  logic [4:0]        Height,
    output logic              Busy,
    output logic              Done,
    output logic [ADDR_W-1:0] Mem_A,
    input  logic [DATA_W-1:0] Mem_Q,
    output logic              Pix_Valid,
    input  logic              Pix_Ready,
    output logic [DATA_W-1:0] Pix_Data,
    output logic [3:0]        Pix_X,
    output logic [3:0]        Pix_Y,
    output logic              Pix_Opaque
);

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [4:0]        w_q, w_d;
    logic [9:0]        n_q, n_d;
    logic [9:0]        issue_cnt_q, issue_cnt_d;
    logic [9:0]        xfer_cnt_q, xfer_cnt_d;
    logic [ADDR_W-1:0] mem_a_q, mem_a_d;
    logic              issue_q, issue_d;   // Mem_A holds a live read this cycle
    logic              ret_q, ret_d;       // Mem_Q carries returned data this cycle
    logic [3:0]        x_q, x_d;
    logic [3:0]        y_q, y_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [4:0]        w_c, h_c;
    logic [9:0]        n_c;
    logic [2:0]        outstanding;
    logic              issue;
    logic              pop;
    logic              push;
    logic              fifo_full, fifo_empty;
    logic [1:0]        fifo_count;
    pix_t              fifo_din, fifo_dout;

    pix_fifo2 u_fifo (
        .clk   (Clk),
        .rst_n (Reset),
        .push  (push),
        .din   (fifo_din),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign Busy       = busy_q;
    assign Done       = done_q;
    assign Mem_A      = mem_a_q;
    assign Pix_Valid  = !fifo_empty;
    assign Pix_Data   = fifo_dout.data;
    assign Pix_X      = fifo_dout.x;
    assign Pix_Y      = fifo_dout.y;
    assign Pix_Opaque = fifo_dout.opaque;

    always_comb begin
        w_c = clamp_dim(Width);
        h_c = clamp_dim(Height);
        n_c = {5'd0, w_c} * {5'd0, h_c};

        pop  = Pix_Valid && Pix_Ready;
        push = ret_q && (!fifo_full || pop);

        fifo_din.data   = Mem_Q;
        fifo_din.x      = x_q;
        fifo_din.y      = y_q;
        fifo_din.opaque = (Mem_Q != TRANSPARENT);

        // Everything outstanding after this edge (FIFO contents, the read on
        // Mem_A and the data on Mem_Q) must fit in the FIFO if the consumer
        // stalls from now on. A pop this edge frees one slot.
        outstanding = {1'b0, fifo_count} + {2'b0, issue_q} + {2'b0, ret_q};
        issue       = (state_q == FETCH) && ((outstanding - {2'b0, pop}) < 3'd2);

        state_d     = state_q;
        base_d      = base_q;
        w_d         = w_q;
        n_d         = n_q;
        issue_cnt_d = issue_cnt_q;
        xfer_cnt_d  = xfer_cnt_q;
        mem_a_d     = mem_a_q;
        issue_d     = issue;
        ret_d       = issue_q;
        x_d         = x_q;
        y_d         = y_q;
        busy_d      = busy_q;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (Start) begin
                    if (n_c == 10'd0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d     = FETCH;
                        base_d      = Base;
                        w_d         = w_c;
                        n_d         = n_c;
                        issue_cnt_d = 10'd0;
                        xfer_cnt_d  = 10'd0;
                        x_d         = 4'd0;
                        y_d         = 4'd0;
                    end
                end
            end
            FETCH: begin
                busy_d = 1'b1;
                if (issue) begin
                    mem_a_d     = base_q + issue_cnt_q[ADDR_W-1:0];
                    issue_cnt_d = issue_cnt_q + 10'd1;
                    if (issue_cnt_q == n_q - 10'd1) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                busy_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Position of the next returned pixel: raster order within the sprite.
        if (push) begin
            if ({1'b0, x_q} == w_q - 5'd1) begin
                x_d = 4'd0;
                y_d = y_q + 4'd1;
            end else begin
                x_d = x_q + 4'd1;
            end
        end

        if (pop && (state_q != IDLE)) begin
            xfer_cnt_d = xfer_cnt_q + 10'd1;
            if (xfer_cnt_q == n_q - 10'd1) begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q     <= IDLE;
            base_q      <= '0;
            w_q         <= 5'd0;
            n_q         <= 10'd0;
            issue_cnt_q <= 10'd0;
            xfer_cnt_q  <= 10'd0;
            mem_a_q     <= '0;
            issue_q     <= 1'b0;
            ret_q       <= 1'b0;
            x_q         <= 4'd0;
            y_q         <= 4'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            w_q         <= w_d;
            n_q         <= n_d;
            issue_cnt_q <= issue_cnt_d;
            xfer_cnt_q  <= xfer_cnt_d;
            mem_a_q     <= mem_a_d;
            issue_q     <= issue_d;
            ret_q       <= ret_d;
            x_q         <= x_d;
            y_q         <= y_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

endmodule

// File: tb/tb_sprite_fetch.sv
// tb_sprite_fetch
//   Directed bench for sprite_fetch with a registered colour memory model,
//   a transfer monitor and a stall-stability monitor.
module tb_sprite_fetch;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] base;
    logic [4:0] width;
    logic [4:0] height;
    logic       busy;
    logic       done;
    logic [7:0] mem_a;
    logic [7:0] mem_q;
    logic       pix_valid;
    logic       pix_ready;
    logic [7:0] pix_data;
    logic [3:0] pix_x;
    logic [3:0] pix_y;
    logic       pix_opaque;

    int total = 0;
    int bad   = 0;

    logic [7:0]  mem [256];
    logic [16:0] xq [$];
    int          done_cnt = 0;
    int          ready_mode = 0;
    int          rcyc = 0;
    logic        hold_pend = 1'b0;
    logic [16:0] hold_prev = '0;

    sprite_fetch dut (
        .Clk        (clk),
        .Reset      (rst_n),
        .Start      (start),
        .Base       (base),
        .Width      (width),
        .Height     (height),
        .Busy       (busy),
        .Done       (done),
        .Mem_A      (mem_a),
        .Mem_Q      (mem_q),
        .Pix_Valid  (pix_valid),
        .Pix_Ready  (pix_ready),
        .Pix_Data   (pix_data),
        .Pix_X      (pix_x),
        .Pix_Y      (pix_y),
        .Pix_Opaque (pix_opaque)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Registered colour memory: data for Mem_A appears one cycle later.
    always @(posedge clk) mem_q <= mem[mem_a];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Ready pattern: mode 0 always ready, mode 1 repeats 1,0,0,1.
    initial begin
        pix_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            rcyc++;
            if (ready_mode == 0) pix_ready = 1'b1;
            else pix_ready = ((rcyc % 4) == 0) || ((rcyc % 4) == 3);
        end
    end

    // Transfer capture, Done counting and hold-during-stall checks.
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend)
                chk("hold", {15'd0, pix_valid, pix_data, pix_x, pix_y, pix_opaque},
                    {15'd0, 1'b1, hold_prev});
            if (pix_valid && pix_ready) xq.push_back({pix_data, pix_x, pix_y, pix_opaque});
            if (done) done_cnt++;
            hold_pend = pix_valid && !pix_ready;
            hold_prev = {pix_data, pix_x, pix_y, pix_opaque};
        end
    end

    task automatic check_pixels(input logic [7:0] b, input int we, input int n);
        logic [7:0]  a;
        logic [16:0] e;
        chk("n_xfer", xq.size(), n);
        for (int i = 0; i < n && i < xq.size(); i++) begin
            a = b + 8'(i);
            e = {mem[a], 4'(i % we), 4'(i / we), (mem[a] != 8'h00)};
            chk("pix", {15'd0, xq[i]}, {15'd0, e});
        end
    endtask

    task automatic run_sprite(input logic [7:0] b, input logic [4:0] w, input logic [4:0] h,
                              input int mode);
        int we, he;
        bit got_done;
        we = (w > 16) ? 16 : int'(w);
        he = (h > 16) ? 16 : int'(h);
        ready_mode = mode;
        xq.delete();
        done_cnt = 0;
        @(posedge clk);
        #1;
        start = 1'b1; base = b; width = w; height = h;
        @(posedge clk);
        #1;
        start = 1'b0;
        got_done = 1'b0;
        for (int i = 0; i < 3000 && !got_done; i++) begin
            @(posedge clk);
            #1;
            if (done) got_done = 1'b1;
        end
        chk("done_seen", got_done, 1);
        chk("busy_end", busy, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("done_cnt", done_cnt, 1);
        check_pixels(b, we, we * he);
    endtask

    logic [7:0] a_saved;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i * 7 + 3);
        rst_n = 1'b0;
        start = 1'b0; base = 8'h00; width = 5'd0; height = 5'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_mema", mem_a, 0);
        chk("rst_valid", pix_valid, 0);
        chk("rst_pix", {pix_data, pix_x, pix_y, pix_opaque}, 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Two opaque pixels with exact cycle timing.
        mem[3] = 8'h49; mem[4] = 8'h49;
        ready_mode = 0; xq.delete(); done_cnt = 0;
        @(posedge clk);
        #1;
        start = 1'b1; base = 8'h03; width = 5'd2; height = 5'd1;
        @(posedge clk);                       // edge 0
        #1;
        start = 1'b0;
        chk("busy_e0", busy, 0);
        @(posedge clk); #1;                   // edge 1
        chk("busy_e1", busy, 1);
        chk("mema_e1", mem_a, 8'h03);
        @(posedge clk); #1;                   // edge 2
        chk("mema_e2", mem_a, 8'h04);
        chk("valid_e2", pix_valid, 0);
        @(posedge clk); #1;                   // edge 3
        chk("valid_e3", pix_valid, 1);
        @(posedge clk); #1;                   // edge 4
        chk("done_e4", done, 0);
        @(posedge clk); #1;                   // edge 5
        chk("done_e5", done, 1);
        chk("busy_e5", busy, 0);
        @(posedge clk); #1;
        chk("done_e6", done, 0);
        chk("n_done1", done_cnt, 1);
        chk("t1_px0", {15'd0, xq.size() > 0 ? xq[0] : 17'h0}, {15'd0, 8'h49, 4'd0, 4'd0, 1'b1});
        chk("t1_px1", {15'd0, xq.size() > 1 ? xq[1] : 17'h0}, {15'd0, 8'h49, 4'd1, 4'd0, 1'b1});
        chk("t1_n", xq.size(), 2);

        // Address wrap FE,FF,00,01.
        run_sprite(8'hFE, 5'd4, 5'd1, 0);

        // Backpressure across a row wrap.
        run_sprite(8'h00, 5'd16, 5'd2, 1);

        // Zero-sized sprite: Done next cycle, no reads, no Busy.
        a_saved = mem_a;
        @(posedge clk);
        #1;
        start = 1'b1; base = 8'h55; width = 5'd0; height = 5'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("zero_done", done, 1);
        chk("zero_busy", busy, 0);
        chk("zero_mema", mem_a, a_saved);
        @(posedge clk); #1;
        chk("zero_done2", done, 0);
        chk("zero_busy2", busy, 0);
        chk("zero_mema2", mem_a, a_saved);

        // Width above 16 clamps to 16.
        run_sprite(8'h80, 5'd20, 5'd1, 0);

        // Transparent and opaque colours.
        mem[8'h10] = 8'h00; mem[8'h11] = 8'hD9;
        run_sprite(8'h10, 5'd2, 5'd1, 1);
        chk("opaque_00", xq.size() > 0 ? xq[0][0] : 1'b1, 0);
        chk("opaque_d9", xq.size() > 1 ? xq[1][0] : 1'b0, 1);

        // Reset mid-sprite with a read in flight.
        ready_mode = 0; xq.delete(); done_cnt = 0;
        @(posedge clk);
        #1;
        start = 1'b1; base = 8'h40; width = 5'd16; height = 5'd2;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_busy", busy, 0);
        chk("mrst_done", done, 0);
        chk("mrst_mema", mem_a, 0);
        chk("mrst_valid", pix_valid, 0);
        chk("mrst_pix", {pix_data, pix_x, pix_y, pix_opaque}, 0);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        xq.delete(); done_cnt = 0;
        repeat (6) @(posedge clk);
        #1;
        chk("post_rst_xfer", xq.size(), 0);
        chk("post_rst_done", done_cnt, 0);
        chk("post_rst_busy", busy, 0);
        run_sprite(8'h20, 5'd3, 5'd2, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
